// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding,
// default depth and the 16-bit word-count type carried in the image header.
package loader_pkg;

  localparam int DEPTH_DEF = 256;

  typedef logic [15:0] word_count_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } loader_state_e;

  // A usable image holds at least one word and fits in the memory.
  function automatic logic length_ok(input word_count_t n, input int depth);
    return (n != '0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes LSB-first into a 32-bit word and flags the byte
// that completes the word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  count,
  output logic        word_ready
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift) begin
      // Newest byte enters at the top, so the first byte ends up in [7:0].
      word  <= {byte_in, word[31:8]};
      count <= count + 2'd1;
    end
  end

  assign word_ready = shift && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: reads a little-endian word count, packs the
// following bytes into instruction-memory writes and verifies an XOR checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output loader_state_e dbg_state
);

  // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
  // are both high; rx_ready depends only on state, never on rx_valid.
  loader_state_e state, state_next;

  word_count_t   len;
  logic [AW-1:0] word_idx;
  logic [7:0]    checksum;
  logic          accept;
  logic          last_word;
  logic          packer_clear;
  logic          packer_shift;
  logic [31:0]   packed_word;
  logic [1:0]    byte_cnt;
  logic          word_ready;

  assign accept       = rx_valid && rx_ready;
  assign last_word    = (word_idx == AW'(len - 16'd1));
  assign packer_clear = (state == ST_LEN1) && accept;
  assign packer_shift = (state == ST_DATA) && accept;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .shift      (packer_shift),
    .byte_in    (rx_data),
    .word       (packed_word),
    .count      (byte_cnt),
    .word_ready (word_ready)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN0;
      ST_LEN0:  if (accept) state_next = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          state_next = length_ok({rx_data, len[7:0]}, DEPTH) ? ST_DATA : ST_ERR;
        end
      end
      ST_DATA:  if (word_ready) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_CHECK : ST_DATA;
      ST_CHECK: begin
        if (accept) state_next = (rx_data == checksum) ? ST_DONE : ST_ERR;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    rx_ready = 1'b0;
    imem_we  = 1'b0;
    cpu_hold = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // Session datapath: word count, write index and running checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      word_idx <= '0;
      checksum <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            len      <= '0;
            word_idx <= '0;
            checksum <= '0;
          end
        end
        ST_LEN0: if (accept) len[7:0] <= rx_data;
        ST_LEN1: begin
          if (accept) begin
            len[15:8] <= rx_data;
            word_idx  <= '0;
            checksum  <= '0;
          end
        end
        ST_DATA:  if (accept) checksum <= checksum ^ rx_data;
        ST_WRITE: if (!last_word) word_idx <= word_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign imem_addr  = word_idx;
  assign imem_wdata = packed_word;
  assign dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: builds byte images from a word list,
// predicts writes and final status from the load rules, and checks them.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int W     = AW + 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  loader_state_e dbg_state;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int last_wr = 0;
  int n_writes = 0;
  bit steady = 1'b0;

  logic [7:0]   tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [31:0]  img[$];

  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (reset && imem_we) begin
      check("ready_in_write", 32'(rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[W-1:32]));
        check("wr_data", imem_wdata, e[31:0]);
      end
      if (steady && n_writes > 0) check("write_gap", 32'(cycle - last_wr), 32'd5);
      last_wr = cycle;
      n_writes++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_flags"}, {29'd0, busy, done, error}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Driver: offers tx_q[0..nmax-1]; random mode also throws in spurious starts
  task automatic drive_stream(input bit rand_valid, input int nmax);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < nmax && guard < 20000) begin
      @(negedge clk);
      rx_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      rx_data  = rx_valid ? tx_q[idx] : 8'($urandom);
      start    = rand_valid && ($urandom_range(0, 7) == 0);
      #1;
      acc = rx_valid && rx_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    if (idx < nmax) check("stream_timeout", 32'(idx), 32'(nmax));
  endtask

  // Reference: image -> byte stream, expected writes and final status
  task automatic build_image(input word_count_t n, input bit good_sum, output bit len_ok);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    len_ok = (n != 0) && (int'(n) <= DEPTH);
    tx_q.delete();
    exp_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    if (len_ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) begin
          b = img[i][8*k +: 8];
          tx_q.push_back(b);
          sum = sum ^ b;
        end
        exp_q.push_back({AW'(i), img[i]});
      end
      tx_q.push_back(good_sum ? sum : (sum ^ 8'h5A));
    end
  endtask

  task automatic run_session(input string tag, input word_count_t n,
                             input bit good_sum, input bit rand_valid);
    bit len_ok;
    bit ok;
    int n_exp;
    build_image(n, good_sum, len_ok);
    n_exp = exp_q.size();
    ok = len_ok && good_sum;
    n_writes = 0;
    steady = !rand_valid;
    pulse_start();
    drive_stream(rand_valid, tx_q.size());
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_error"}, 32'(error), 32'(!ok));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(n_writes), 32'(n_exp));
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_stable"}, {30'd0, done, error}, {30'd0, ok, !ok});
  endtask

  task automatic random_image(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    int n;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("idle");

    // Two-instruction image
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h00A0_0093);
    run_session("n2", 16'd2, 1'b1, 1'b0);

    // Length boundaries
    run_session("n0", 16'd0, 1'b1, 1'b0);
    run_session("n257", 16'd257, 1'b1, 1'b0);
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(32'hFFFF_FFFF);
    run_session("n256", 16'd256, 1'b1, 1'b0);

    // Bad checksum after one word
    random_image(1);
    run_session("badsum", 16'd1, 1'b0, 1'b0);

    // Random images, each sent back-to-back and then with gappy valid
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 9);
      random_image(n);
      run_session("rnd_steady", word_count_t'(n), 1'b1, 1'b0);
      run_session("rnd_gappy", word_count_t'(n), ($urandom_range(0, 3) != 0), 1'b1);
    end

    // Reset after the second data byte abandons the session
    random_image(2);
    build_image(16'd2, 1'b1, steady);
    steady = 1'b0;
    pulse_start();
    drive_stream(1'b0, 4);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    n_writes = 0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("post_rst");
    check("post_rst_writes", 32'(n_writes), 32'd0);
    run_session("after_rst", 16'd2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
